serial_adder_n_bit: RTL and testbench

Multi-cycle, parametrised N-bit adder/subtractor for the processor ALU. It processes CHUNK bits per clock with a registered carry, trading latency for area. It adds a subtract mode, NZCV-style status flags and a start/done/ack handshake. It sits beside the combinational ALU datapath and is driven by the ALU control FSM.

---
 rtl/serial_adder_n_bit.sv | 195 +++++++++++++++++++
 tb/tb_serial_adder_n_bit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_n_bit.sv
// serial_adder_n_bit
//   Multi-cycle WIDTH-bit adder/subtractor. Each RUN cycle adds one CHUNK-bit slice of the
//   captured operands plus a registered carry, so an operation takes NCHUNK = WIDTH/CHUNK
//   cycles. Subtraction is a + ~b + 1. The result and NZCV-style flags are registered and
//   change only when an operation completes.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   request; accepted in IDLE, or in DONE together with ack
//   sub       in   0: a + b + c_in, 1: a - b (c_in ignored)
//   a, b      in   operands, captured on accept
//   c_in      in   carry in for add mode, captured on accept
//   ack       in   consumer has taken the result (used only while done=1)
//   busy      out  operation in progress
//   done      out  result and flags valid
//   result    out  sum / difference
//   c_out     out  carry out of MSB (for subtract, 1 = no borrow)
//   overflow  out  signed overflow
//   zero      out  result == 0
//   negative  out  result MSB
module serial_adder_n_bit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  // Guarded so a zero CHUNK reaches the check below instead of dividing by zero.
  localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
  localparam bit BAD_PARAMS = (CHUNK == 0) ? 1'b1
                            : ((CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0));

  if (BAD_PARAMS) begin : g_bad_params
    $error("serial_adder_n_bit: WIDTH must be a nonzero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;     // already inverted for subtract
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] shadow_q, shadow_d; // partial sums, never driven to the outputs
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;

  // ---------------------------------------------------------------------------
  // Chunk datapath
  // ---------------------------------------------------------------------------
  logic [31:0]      bit_pos;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] full_sum;
  logic             msb_carry_in;
  logic             accept;
  logic             last_chunk;

  always_comb begin
    bit_pos    = 32'(idx_q) * CHUNK;
    chunk_a    = CHUNK'(op_a_q >> bit_pos);
    chunk_b    = CHUNK'(op_b_q >> bit_pos);
    chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << bit_pos;
    full_sum   = (shadow_q & ~chunk_mask)
               | ((WIDTH'(chunk_sum[CHUNK-1:0]) << bit_pos) & chunk_mask);
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB is recovered from the sum bit.
    // Only meaningful on the last chunk, where chunk_sum[CHUNK-1] is the result MSB.
    msb_carry_in = op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1] ^ chunk_sum[CHUNK-1];
    last_chunk   = (idx_q == LAST_IDX);
  end

  // ---------------------------------------------------------------------------
  // Control: next state and register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    carry_d    = carry_q;
    shadow_d   = shadow_q;
    result_d   = result_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    accept     = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = start;
      end
      StRun: begin
        shadow_d = full_sum;
        carry_d  = chunk_sum[CHUNK];
        idx_d    = idx_q + 1'b1;
        if (last_chunk) begin
          result_d   = full_sum;
          c_out_d    = chunk_sum[CHUNK];
          overflow_d = msb_carry_in ^ chunk_sum[CHUNK];
          zero_d     = (full_sum == '0);
          negative_d = full_sum[WIDTH-1];
          idx_d      = '0;
          state_d    = StDone;
        end
      end
      StDone: begin
        // Without ack, start is ignored and the result is held.
        if (ack) begin
          accept  = start;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared by IDLE and by DONE+ack, giving back-to-back operation without a bubble.
    if (accept) begin
      op_a_d  = a;
      op_b_d  = sub ? ~b : b;
      carry_d = sub | c_in;
      idx_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      carry_q    <= 1'b0;
      shadow_q   <= '0;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      carry_q    <= carry_d;
      shadow_q   <= shadow_d;
      result_q   <= result_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign result   = result_q;
  assign c_out    = c_out_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_serial_adder_n_bit.sv
// Directed bench for serial_adder_n_bit with WIDTH=8, CHUNK=4 (two RUN cycles).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_adder_n_bit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CHUNK = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             ack;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  int checks;
  int errors;

  serial_adder_n_bit #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [7:0] r, input logic co,
                             input logic ov, input logic z, input logic n);
    check({tag, " result"}, 32'(result), 32'(r));
    check({tag, " c_out"}, 32'(c_out), 32'(co));
    check({tag, " overflow"}, 32'(overflow), 32'(ov));
    check({tag, " zero"}, 32'(zero), 32'(z));
    check({tag, " negative"}, 32'(negative), 32'(n));
  endtask

  // Issue one operation starting at a falling edge; returns at the falling edge where
  // done is first expected, having checked the busy/done timing on the way.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tcin, input logic tsub);
    a     = ta;
    b     = tb_v;
    c_in  = tcin;
    sub   = tsub;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy run0"}, 32'(busy), 32'd1);
    check({tag, " done run0"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, " busy run1"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy in done"}, 32'(busy), 32'd0);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({tag, " done after ack"}, 32'(done), 32'd0);
    check({tag, " busy after ack"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    sub    = 1'b0;
    a      = '0;
    b      = '0;
    c_in   = 1'b0;
    ack    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check_flags("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Idle with start low stays idle
    repeat (2) @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);
    check("idle done", 32'(done), 32'd0);

    // 1. Add with signed overflow: 0x3C + 0x45 = 0x81
    run_op("t1", 8'h3C, 8'h45, 1'b0, 1'b0);
    check_flags("t1", 8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
    do_ack("t1");

    // 2. Subtract to zero: 0x10 - 0x10
    run_op("t2", 8'h10, 8'h10, 1'b0, 1'b1);
    check_flags("t2", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    do_ack("t2");

    // 3. Carry out, no overflow: 0xFF + 0x01 + 1 = 0x101
    run_op("t3", 8'hFF, 8'h01, 1'b1, 1'b0);
    check_flags("t3", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    do_ack("t3");

    // 4. Subtract with signed overflow: 0x80 - 0x01 = 0x7F
    run_op("t4", 8'h80, 8'h01, 1'b0, 1'b1);
    check_flags("t4", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    do_ack("t4");

    // 5. Handshake robustness: operands changed and start pulsed during RUN
    a     = 8'h22;
    b     = 8'h11;
    c_in  = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    sub   = 1'b1;
    c_in  = 1'b1;
    check("t5 busy run0", 32'(busy), 32'd1);
    check("t5 result hidden run0", 32'(result), 32'h7F);
    @(negedge clk);
    start = 1'b0;
    check("t5 busy run1", 32'(busy), 32'd1);
    check("t5 result hidden run1", 32'(result), 32'h7F);
    @(negedge clk);
    check("t5 done", 32'(done), 32'd1);
    check_flags("t5", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    // Hold ack low for 5 cycles, with start high to show it is ignored.
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5 hold done", 32'(done), 32'd1);
      check("t5 hold busy", 32'(busy), 32'd0);
      check("t5 hold result", 32'(result), 32'h33);
    end
    // ack with start: back-to-back accept of 0x01 + 0x02
    a    = 8'h01;
    b    = 8'h02;
    sub  = 1'b0;
    c_in = 1'b0;
    ack  = 1'b1;
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
    check("t5 b2b busy", 32'(busy), 32'd1);
    check("t5 b2b done low", 32'(done), 32'd0);
    check("t5 b2b result held", 32'(result), 32'h33);
    @(negedge clk);
    check("t5 b2b busy run1", 32'(busy), 32'd1);
    @(negedge clk);
    check("t5 b2b done", 32'(done), 32'd1);
    check_flags("t5 b2b", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    do_ack("t5 b2b");

    // 6. Asynchronous reset in the second RUN cycle
    a     = 8'hFF;
    b     = 8'h01;
    c_in  = 1'b1;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t6 busy before rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6 rst busy", 32'(busy), 32'd0);
    check("t6 rst done", 32'(done), 32'd0);
    check_flags("t6 rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6 idle after rst", 32'(busy | done), 32'd0);
    run_op("t6 fresh", 8'h0F, 8'h01, 1'b0, 1'b0);
    check_flags("t6 fresh", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    do_ack("t6 fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
